// File: rtl/decode_issue_pkg.sv
// Opcode, field-position and FSM-state definitions shared by decode/issue and execute.
package decode_issue_pkg;

  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_LOAD  = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd5;
  localparam logic [5:0] OP_STORE = 6'd6;
  localparam logic [5:0] OP_BNEZ  = 6'd9;
  localparam logic [5:0] OP_HALT  = 6'd10;

  localparam int OPC_HI = 31, OPC_LO = 26;
  localparam int RS1_HI = 25, RS1_LO = 21;
  localparam int RS2_HI = 20, RS2_LO = 16;
  localparam int RDR_HI = 15, RDR_LO = 11;
  localparam int IMM_HI = 15, IMM_LO = 0;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  typedef struct packed {
    logic [5:0]  alu_func;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] offset;
    logic        use_rs1;
    logic        use_rs2;
    logic        is_halt;
    logic        is_illegal;
  } dec_t;

  // Unlisted opcodes decode to an all-zero NOP with is_illegal set.
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t        d;
    logic [31:0] sext;
    d      = '0;
    sext   = {{16{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
    d.rs1  = instr[RS1_HI:RS1_LO];
    d.rs2  = instr[RS2_HI:RS2_LO];
    case (instr[OPC_HI:OPC_LO])
      OP_NOP: d.alu_func = OP_NOP;
      OP_ADD: begin
        d.alu_func = OP_ADD;
        d.use_rs1  = 1'b1;
        d.use_rs2  = 1'b1;
        d.rd       = instr[RDR_HI:RDR_LO];
      end
      OP_LOAD, OP_ADDI: begin
        d.alu_func = instr[OPC_HI:OPC_LO];
        d.use_rs1  = 1'b1;
        d.rd       = instr[RS2_HI:RS2_LO];
        d.offset   = sext;
      end
      OP_STORE: begin
        d.alu_func = OP_STORE;
        d.use_rs1  = 1'b1;
        d.use_rs2  = 1'b1;
        d.offset   = sext;
      end
      OP_BNEZ: begin
        d.alu_func = OP_BNEZ;
        d.use_rs1  = 1'b1;
        d.offset   = sext;
      end
      OP_HALT: begin
        d.alu_func = OP_HALT;
        d.is_halt  = 1'b1;
      end
      default: d.is_illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_regfile_2r1w.sv
// 32x32 register file: two combinational read ports, one synchronous write, R0 hardwired to zero.
module regfile_2r1w
  import decode_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_data_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] mem_q [32];
  logic [31:0] mem_d [32];

  always_comb begin
    mem_d = mem_q;
    if (wr_en && wr_addr != 5'd0) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : mem_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : mem_q[rd_addr_b];

endmodule

// File: rtl/decode_issue.sv
// Decode and issue stage: register read with optional writeback bypass, busy-bit scoreboard, halt FSM.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter bit ENABLE_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid_pi,
  input  logic [31:0] instr_pi,
  output logic        instr_ready_po,
  output logic [31:0] op1_po,
  output logic [31:0] op2_po,
  output logic [5:0]  aluFunc_po,
  output logic [31:0] offset_po,
  output logic [4:0]  rd_po,
  output logic        issue_valid_po,
  input  logic        issue_ready_pi,
  input  logic        wb_en_pi,
  input  logic [4:0]  wb_rd_pi,
  input  logic [31:0] wb_data_pi,
  output logic        halted_po,
  output logic        illegal_po
);

  dec_t        dec;
  logic [31:0] rf_a, rf_b;
  logic        hit1, hit2, haz1, haz2, hazard, accept;
  logic [31:0] op1_sel, op2_sel;

  logic        issue_valid_q, issue_valid_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d, offset_q, offset_d;
  logic [5:0]  alu_func_q, alu_func_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] busy_q, busy_d;
  logic [0:0]  state_q, state_d;
  logic        illegal_q, illegal_d;

  assign dec = decode_instr(instr_pi);

  regfile_2r1w u_rf (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (dec.rs1),
    .rd_data_a (rf_a),
    .rd_addr_b (dec.rs2),
    .rd_data_b (rf_b),
    .wr_en     (wb_en_pi),
    .wr_addr   (wb_rd_pi),
    .wr_data   (wb_data_pi)
  );

  // Without bypass a same-cycle writeback to a source must stall: the array still holds the old value.
  always_comb begin
    hit1 = wb_en_pi && (wb_rd_pi == dec.rs1) && (dec.rs1 != 5'd0);
    hit2 = wb_en_pi && (wb_rd_pi == dec.rs2) && (dec.rs2 != 5'd0);
    if (ENABLE_BYPASS) begin
      haz1 = dec.use_rs1 && busy_q[dec.rs1] && !hit1;
      haz2 = dec.use_rs2 && busy_q[dec.rs2] && !hit2;
    end else begin
      haz1 = dec.use_rs1 && (busy_q[dec.rs1] || hit1);
      haz2 = dec.use_rs2 && (busy_q[dec.rs2] || hit2);
    end
    hazard  = haz1 || haz2;
    op1_sel = !dec.use_rs1 ? 32'd0 : ((ENABLE_BYPASS && hit1) ? wb_data_pi : rf_a);
    op2_sel = !dec.use_rs2 ? 32'd0 : ((ENABLE_BYPASS && hit2) ? wb_data_pi : rf_b);
  end

  assign instr_ready_po = !reset && (state_q == ST_RUN) &&
                          (!issue_valid_q || issue_ready_pi) && !hazard;
  assign accept = instr_valid_pi && instr_ready_po;

  always_comb begin
    issue_valid_d = issue_valid_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    offset_d      = offset_q;
    alu_func_d    = alu_func_q;
    rd_d          = rd_q;
    state_d       = state_q;
    illegal_d     = illegal_q;
    busy_d        = busy_q;
    if (wb_en_pi) busy_d[wb_rd_pi] = 1'b0;
    if (accept) begin
      issue_valid_d = 1'b1;
      op1_d         = op1_sel;
      op2_d         = op2_sel;
      offset_d      = dec.offset;
      alu_func_d    = dec.alu_func;
      rd_d          = dec.rd;
      // Applied after the clear so an issue wins over a same-cycle writeback.
      if (dec.rd != 5'd0) busy_d[dec.rd] = 1'b1;
      if (dec.is_halt || dec.is_illegal) state_d = ST_HALTED;
      if (dec.is_illegal) illegal_d = 1'b1;
    end else if (issue_ready_pi) begin
      issue_valid_d = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid_q <= 1'b0;
      op1_q         <= '0;
      op2_q         <= '0;
      offset_q      <= '0;
      alu_func_q    <= '0;
      rd_q          <= '0;
      busy_q        <= '0;
      state_q       <= ST_RUN;
      illegal_q     <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      offset_q      <= offset_d;
      alu_func_q    <= alu_func_d;
      rd_q          <= rd_d;
      busy_q        <= busy_d;
      state_q       <= state_d;
      illegal_q     <= illegal_d;
    end
  end

  // Outputs are forced low while reset is asserted so the reset cycle itself reads zero.
  assign issue_valid_po = !reset && issue_valid_q;
  assign op1_po         = reset ? 32'd0 : op1_q;
  assign op2_po         = reset ? 32'd0 : op2_q;
  assign offset_po      = reset ? 32'd0 : offset_q;
  assign aluFunc_po     = reset ? 6'd0 : alu_func_q;
  assign rd_po          = reset ? 5'd0 : rd_q;
  assign halted_po      = !reset && (state_q == ST_HALTED);
  assign illegal_po     = !reset && illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: a vector table for the main datapath plus hand sequences for stall, halt and reset.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid_pi;
  logic [31:0] instr_pi;
  logic        instr_ready_po;
  logic [31:0] op1_po, op2_po, offset_po;
  logic [5:0]  aluFunc_po;
  logic [4:0]  rd_po;
  logic        issue_valid_po;
  logic        issue_ready_pi;
  logic        wb_en_pi;
  logic [4:0]  wb_rd_pi;
  logic [31:0] wb_data_pi;
  logic        halted_po, illegal_po;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  decode_issue #(.ENABLE_BYPASS(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_valid_pi (instr_valid_pi),
    .instr_pi       (instr_pi),
    .instr_ready_po (instr_ready_po),
    .op1_po         (op1_po),
    .op2_po         (op2_po),
    .aluFunc_po     (aluFunc_po),
    .offset_po      (offset_po),
    .rd_po          (rd_po),
    .issue_valid_po (issue_valid_po),
    .issue_ready_pi (issue_ready_pi),
    .wb_en_pi       (wb_en_pi),
    .wb_rd_pi       (wb_rd_pi),
    .wb_data_pi     (wb_data_pi),
    .halted_po      (halted_po),
    .illegal_po     (illegal_po)
  );

  always @(posedge clk) if (issue_valid_po && issue_ready_pi) hs_cnt++;

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        ir;
    logic        e_ready;
    logic        e_valid;
    logic        e_data;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [5:0]  e_alu;
    logic [31:0] e_off;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [15:0] imm);
    return {op, a, b, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs, checks the combinational ready before the edge, ends at edge+1.
  task automatic step(input logic iv, input logic [31:0] ins, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd, input logic ir, input logic exp_ready, input string tag);
    instr_valid_pi = iv;
    instr_pi       = ins;
    wb_en_pi       = we;
    wb_rd_pi       = wr;
    wb_data_pi     = wd;
    issue_ready_pi = ir;
    #3;
    chk({tag, ".ready"}, 32'(instr_ready_po), 32'(exp_ready));
    @(posedge clk);
    #1;
    $display("%s: ready=%0b valid=%0b op1=%h op2=%h alu=%0d off=%h rd=%0d halted=%0b illegal=%0b",
             tag, exp_ready, issue_valid_po, op1_po, op2_po, aluFunc_po, offset_po, rd_po,
             halted_po, illegal_po);
  endtask

  task automatic chk_issue(input string tag, input logic v, input logic [31:0] o1, input logic [31:0] o2,
                           input logic [5:0] alu, input logic [31:0] off, input logic [4:0] rd);
    chk({tag, ".valid"}, 32'(issue_valid_po), 32'(v));
    chk({tag, ".op1"},   op1_po, o1);
    chk({tag, ".op2"},   op2_po, o2);
    chk({tag, ".alu"},   32'(aluFunc_po), 32'(alu));
    chk({tag, ".off"},   offset_po, off);
    chk({tag, ".rd"},    32'(rd_po), 32'(rd));
  endtask

  task automatic do_reset(input string tag);
    reset          = 1'b1;
    instr_valid_pi = 1'b0;
    instr_pi       = '0;
    wb_en_pi       = 1'b0;
    wb_rd_pi       = '0;
    wb_data_pi     = '0;
    issue_ready_pi = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_issue(tag, 1'b0, 0, 0, 0, 0, 0);
    chk({tag, ".halted"},  32'(halted_po), 0);
    chk({tag, ".illegal"}, 32'(illegal_po), 0);
  endtask

  initial begin
    // iv ins we wr wd ir | ready valid data op1 op2 alu off rd
    vecs[0]  = '{0, 32'd0, 1, 5'd1, 32'd5, 1,  1, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 32'd0, 1, 5'd2, 32'd7, 1,  1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, enc(6'd1, 5'd1, 5'd2, 16'h1800), 0, 5'd0, 32'd0, 1,
                 1, 1, 1, 32'd5, 32'd7, 6'd1, 32'd0, 5'd3};
    vecs[3]  = '{1, enc(6'd5, 5'd1, 5'd4, 16'hFFFE), 0, 5'd0, 32'd0, 1,
                 1, 1, 1, 32'd5, 32'd0, 6'd5, 32'hFFFF_FFFE, 5'd4};
    vecs[4]  = '{1, enc(6'd1, 5'd4, 5'd2, 16'h2800), 0, 5'd0, 32'd0, 1,
                 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, enc(6'd1, 5'd4, 5'd2, 16'h2800), 1, 5'd4, 32'd100, 1,
                 1, 1, 1, 32'd100, 32'd7, 6'd1, 32'd0, 5'd5};
    vecs[6]  = '{1, enc(6'd4, 5'd3, 5'd6, 16'h0008), 1, 5'd3, 32'd12, 1,
                 1, 1, 1, 32'd12, 32'd0, 6'd4, 32'd8, 5'd6};
    vecs[7]  = '{1, enc(6'd6, 5'd2, 5'd5, 16'hFFFC), 1, 5'd5, 32'd33, 1,
                 1, 1, 1, 32'd7, 32'd33, 6'd6, 32'hFFFF_FFFC, 5'd0};
    vecs[8]  = '{1, enc(6'd9, 5'd1, 5'd0, 16'h0010), 0, 5'd0, 32'd0, 1,
                 1, 1, 1, 32'd5, 32'd0, 6'd9, 32'd16, 5'd0};
    vecs[9]  = '{0, 32'd0, 0, 5'd0, 32'd0, 1,  1, 0, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 32'd0, 1, 5'd0, 32'd99, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, enc(6'd1, 5'd0, 5'd1, 16'h3800), 0, 5'd0, 32'd0, 1,
                 1, 1, 1, 32'd0, 32'd5, 6'd1, 32'd0, 5'd7};

    reset = 1'b1;
    instr_valid_pi = 1'b0; instr_pi = '0; issue_ready_pi = 1'b0;
    wb_en_pi = 1'b0; wb_rd_pi = '0; wb_data_pi = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready_in_reset", 32'(instr_ready_po), 0);
    reset = 1'b0;
    chk_issue("rst", 1'b0, 0, 0, 0, 0, 0);
    chk("rst.halted", 32'(halted_po), 0);
    chk("rst.illegal", 32'(illegal_po), 0);

    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].iv, vecs[i].ins, vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].ir,
           vecs[i].e_ready, tag);
      chk({tag, ".valid"}, 32'(issue_valid_po), 32'(vecs[i].e_valid));
      if (vecs[i].e_data)
        chk_issue(tag, vecs[i].e_valid, vecs[i].e_op1, vecs[i].e_op2, vecs[i].e_alu,
                  vecs[i].e_off, vecs[i].e_rd);
    end

    // Back-pressure: held outputs stay stable and exactly one handshake follows release.
    begin
      int hs_base;
      step(1, enc(6'd1, 5'd1, 5'd2, 16'h4000), 0, 0, 0, 1, 1, "stall.issue");
      chk_issue("stall.issue", 1, 32'd5, 32'd7, 6'd1, 0, 5'd8);
      hs_base = hs_cnt;
      for (int c = 0; c < 3; c++) begin
        step(1, enc(6'd5, 5'd1, 5'd9, 16'h0001), 0, 0, 0, 0, 0, $sformatf("stall.hold%0d", c));
        chk_issue($sformatf("stall.hold%0d", c), 1, 32'd5, 32'd7, 6'd1, 0, 5'd8);
      end
      step(0, 32'd0, 0, 0, 0, 1, 1, "stall.release");
      chk("stall.release.valid", 32'(issue_valid_po), 0);
      chk("stall.handshakes", 32'(hs_cnt - hs_base), 1);
    end

    // HALT is issued downstream, then the stage refuses everything.
    step(1, enc(6'd10, 5'd0, 5'd0, 16'h0000), 0, 0, 0, 1, 1, "halt.issue");
    chk_issue("halt.issue", 1, 0, 0, 6'd10, 0, 0);
    chk("halt.halted", 32'(halted_po), 1);
    for (int c = 0; c < 3; c++) begin
      step(1, enc(6'd1, 5'd1, 5'd2, 16'h4000), 1, 5'd6, 32'd1, 1, 0, $sformatf("halt.idle%0d", c));
      chk($sformatf("halt.idle%0d.valid", c), 32'(issue_valid_po), 0);
      chk($sformatf("halt.idle%0d.halted", c), 32'(halted_po), 1);
    end

    // Unlisted opcode issues as NOP and sets the sticky illegal flag.
    do_reset("rst2");
    step(1, enc(6'h3F, 5'd1, 5'd2, 16'h1234), 0, 0, 0, 1, 1, "ill.issue");
    chk_issue("ill.issue", 1, 0, 0, 6'd0, 0, 0);
    chk("ill.flag", 32'(illegal_po), 1);
    step(1, enc(6'd1, 5'd1, 5'd2, 16'h4000), 0, 0, 0, 1, 0, "ill.after");
    chk("ill.after.flag", 32'(illegal_po), 1);
    chk("ill.after.valid", 32'(issue_valid_po), 0);

    // Reset while an issue is stalled discards it and clears regfile and scoreboard.
    do_reset("rst3");
    step(0, 32'd0, 1, 5'd1, 32'd5, 1, 1, "mid.wb");
    step(1, enc(6'd1, 5'd1, 5'd1, 16'h1800), 0, 0, 0, 0, 1, "mid.issue");
    chk_issue("mid.issue", 1, 32'd5, 32'd5, 6'd1, 0, 5'd3);
    step(1, enc(6'd1, 5'd1, 5'd2, 16'h4000), 0, 0, 0, 0, 0, "mid.stall");
    reset = 1'b1;
    wb_en_pi = 1'b1; wb_rd_pi = 5'd2; wb_data_pi = 32'd9;
    #3;
    chk("mid.rstcyc.ready", 32'(instr_ready_po), 0);
    chk("mid.rstcyc.valid", 32'(issue_valid_po), 0);
    chk("mid.rstcyc.op1", op1_po, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_issue("mid.after", 0, 0, 0, 0, 0, 0);
    step(1, enc(6'd1, 5'd3, 5'd1, 16'h2800), 0, 0, 0, 1, 1, "mid.r3r1");
    chk_issue("mid.r3r1", 1, 0, 0, 6'd1, 0, 5'd5);
    step(1, enc(6'd1, 5'd2, 5'd0, 16'h3000), 0, 0, 0, 1, 1, "mid.r2");
    chk_issue("mid.r2", 1, 0, 0, 6'd1, 0, 5'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
